// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants, tracking-entry type and counter helper for the branch predictor
package bp_pkg;

  localparam int PHT_DEPTH = 32;
  localparam int IDX_W     = 5;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [5:0] OPC_BEQ = 6'b000100;

  localparam int TRK_VALID_W = 1;
  localparam int TRK_PRED_W  = 1;
  localparam int TRK_IDX_W   = IDX_W;

  typedef struct packed {
    logic [TRK_VALID_W-1:0] valid;
    logic [TRK_PRED_W-1:0]  pred_taken;
    logic [TRK_IDX_W-1:0]   idx;
  } trk_t;

  // Saturating 2-bit step: never wraps past strongly taken / strongly not-taken
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_pht.sv
// rtl/bp_pht.sv - pattern history table of 2-bit counters, comb read, saturating update
module bp_pht
  import bp_pkg::*;
#(
  parameter logic [1:0] CTR_RESET = CTR_WNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] ctr [PHT_DEPTH];

  // Read returns the registered value, so a same-cycle update is not visible until next cycle
  assign rd_ctr = ctr[rd_idx];

  // Counter storage: async clear to the reset bias, one saturating update per resolve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_DEPTH; i++) ctr[i] <= CTR_RESET;
    end else if (upd_en) begin
      ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// rtl/branch_predict_resolve.sv - PHT lookup, 3-stage prediction tracking and EX/MEM resolve (optional stats: BP_STATS_EN)
module branch_predict_resolve
  import bp_pkg::*;
#(
  parameter logic [1:0] CTR_RESET = CTR_WNT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_is_branch,
  input  logic        ex_branch_valid,
  input  logic        ex_branch_taken,
  output logic [1:0]  pred_bit_out,
  output logic        predictor_wrong
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  logic [IDX_W-1:0] fetch_idx;
  logic             unused_pc_bits;
  logic             resolve;
  trk_t             capture;
  trk_t             stg0, stg1, stg2;
  trk_t             stg0_d, stg1_d, stg2_d;

  // Word-aligned PC: byte offset bits and high bits play no part in indexing
  assign fetch_idx      = fetch_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0]};

  bp_pht #(
    .CTR_RESET (CTR_RESET)
  ) u_pht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (fetch_idx),
    .rd_ctr    (pred_bit_out),
    .upd_en    (resolve),
    .upd_idx   (stg2.idx),
    .upd_taken (ex_branch_taken)
  );

  // A branch fetched in the same cycle as a mispredict is on the wrong path, so it never tracks
  assign capture.valid      = fetch_is_branch & ~predictor_wrong;
  assign capture.pred_taken = pred_bit_out[1];
  assign capture.idx        = fetch_idx;

  assign resolve         = ex_branch_valid & stg2.valid;
  assign predictor_wrong = resolve & (ex_branch_taken != stg2.pred_taken);

  // Next tracking state: shift on advance, hold on stall (retiring a consumed stg2), wipe on flush
  always_comb begin
    stg0_d = stg0;
    stg1_d = stg1;
    stg2_d = stg2;
    if (pc_write) begin
      stg0_d = capture;
      stg1_d = stg0;
      stg2_d = stg1;
    end else if (resolve) begin
      stg2_d.valid = 1'b0;
    end
    if (predictor_wrong) begin
      stg0_d.valid = 1'b0;
      stg1_d.valid = 1'b0;
      stg2_d.valid = 1'b0;
    end
  end

  // Tracking pipe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg0 <= '0;
      stg1 <= '0;
      stg2 <= '0;
    end else begin
      stg0 <= stg0_d;
      stg1 <= stg1_d;
      stg2 <= stg2_d;
    end
  end

`ifdef BP_STATS_EN
  // Free-running resolve / mispredict counters, wrapping modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (resolve)         stat_branches    <= stat_branches + 32'd1;
      if (predictor_wrong) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule
